// File: rtl/mem_stage.sv
// mem_stage: memory stage of the ARM pipeline, directly downstream of Exec.
// Owns the EX/MEM and MEM/WB pipeline registers and drives a variable-latency
// data-memory req/ready port. The upstream pipe stalls during wait states.
// Each access aborts after TIMEOUT wait cycles.
//
// Ports:
//   clk, reset                  clock (rising edge), async active-low reset
//   flushM                      bubble the instruction entering EX/MEM
//   PCSrcE..MemtoRegE           condition-gated controls from Exec
//   ALUResultE, WriteDataE      address / ALU result and store data from Exec
//   WriteAddrE                  destination register
//   stallM                      hold upstream stages and EX/MEM this cycle
//   ALUResultM, WriteAddrM,
//   RegWriteM                   EX/MEM contents for forwarding / hazard unit
//   dmem_*                      data-memory request port
//   PCSrcW..WriteAddrW          MEM/WB contents
//   ResultW                     writeback value (load data or ALU result)
//   mem_err                     sticky flag for a timeout or misaligned access
module mem_stage #(
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] BAD_RDATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flushM,
   input  logic        PCSrcE,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        MemtoRegE,
   input  logic [31:0] ALUResultE,
   input  logic [31:0] WriteDataE,
   input  logic [3:0]  WriteAddrE,
   output logic        stallM,
   output logic [31:0] ALUResultM,
   output logic [3:0]  WriteAddrM,
   output logic        RegWriteM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        PCSrcW,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [3:0]  WriteAddrW,
   output logic [31:0] ResultW,
   output logic        mem_err
);

   localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

   typedef enum logic {StIdle, StWait} state_t;

   state_t      state_q, state_d;
   logic [15:0] wcnt_q, wcnt_d;

   logic        PCSrcM, MemWriteM, MemtoRegM;
   logic [31:0] WriteDataM;

   logic ld, st, acc;
   logic timeout_hit, abort;

   // A load whose condition failed arrives with RegWrite cleared and never issues.
   assign ld  = MemtoRegM & RegWriteM;
   assign st  = MemWriteM;
   assign acc = ld | st;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         StIdle: begin
            if (acc && !dmem_ready) begin
               state_d = StWait;
               wcnt_d  = 16'd1;
            end
         end
         StWait: begin
            // ready has priority over the timeout count
            if (!acc || dmem_ready || timeout_hit) begin
               state_d = StIdle;
               wcnt_d  = '0;
            end else begin
               wcnt_d = 16'(wcnt_q + 16'd1);
            end
         end
         default: begin
            state_d = StIdle;
            wcnt_d  = '0;
         end
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      timeout_hit = (state_q == StWait) && (wcnt_q == TimeoutCnt);
      abort       = acc && !dmem_ready && timeout_hit;
      stallM      = acc && !dmem_ready && !timeout_hit;
      dmem_req    = acc;
      dmem_we     = st;
      dmem_addr   = {ALUResultM[31:2], 2'b00};
      dmem_wdata  = WriteDataM;
   end

   // ---------------- EX/MEM ----------------
   // Stall takes priority over flush so a stalled access always completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PCSrcM     <= 1'b0;
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         MemtoRegM  <= 1'b0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         WriteAddrM <= '0;
      end else if (!stallM) begin
         if (flushM) begin
            PCSrcM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            WriteAddrM <= '0;
         end else begin
            PCSrcM     <= PCSrcE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            MemtoRegM  <= MemtoRegE;
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            WriteAddrM <= WriteAddrE;
         end
      end
   end

   // ---------------- MEM/WB ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PCSrcW     <= 1'b0;
         RegWriteW  <= 1'b0;
         MemtoRegW  <= 1'b0;
         ReadDataW  <= '0;
         ALUOutW    <= '0;
         WriteAddrW <= '0;
      end else if (stallM) begin
         PCSrcW    <= 1'b0;
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
      end else begin
         PCSrcW     <= PCSrcM;
         RegWriteW  <= RegWriteM;
         MemtoRegW  <= MemtoRegM;
         ALUOutW    <= ALUResultM;
         WriteAddrW <= WriteAddrM;
         if (!ld)        ReadDataW <= '0;
         else if (abort) ReadDataW <= BAD_RDATA;
         else            ReadDataW <= dmem_rdata;
      end
   end

   assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

   // ---------------- sticky error ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_err <= 1'b0;
      end else if (abort || (acc && (ALUResultM[1:0] != 2'b00))) begin
         mem_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flushM;
   logic        PCSrcE, RegWriteE, MemWriteE, MemtoRegE;
   logic [31:0] ALUResultE, WriteDataE;
   logic [3:0]  WriteAddrE;
   logic        stallM;
   logic [31:0] ALUResultM;
   logic [3:0]  WriteAddrM;
   logic        RegWriteM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ready;
   logic        PCSrcW, RegWriteW, MemtoRegW;
   logic [31:0] ReadDataW, ALUOutW, ResultW;
   logic [3:0]  WriteAddrW;
   logic        mem_err;

   int n_vec = 0;
   int n_err = 0;

   mem_stage #(.TIMEOUT(4), .BAD_RDATA(32'hDEADBEEF)) dut (
      .clk(clk), .reset(reset), .flushM(flushM),
      .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WriteAddrE(WriteAddrE),
      .stallM(stallM), .ALUResultM(ALUResultM), .WriteAddrM(WriteAddrM), .RegWriteM(RegWriteM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
      .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteAddrW(WriteAddrW),
      .ResultW(ResultW), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_e(input logic pc, input logic rw, input logic mw, input logic m2r,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa);
      PCSrcE = pc; RegWriteE = rw; MemWriteE = mw; MemtoRegE = m2r;
      ALUResultE = alu; WriteDataE = wd; WriteAddrE = wa;
   endtask

   task automatic nop_e;
      drive_e(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; flushM = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
      nop_e();
      #12;
      check("rst_stall",   {31'b0, stallM},    0);
      check("rst_req",     {31'b0, dmem_req},  0);
      check("rst_result",  ResultW,            0);
      check("rst_regwrw",  {31'b0, RegWriteW}, 0);
      check("rst_err",     {31'b0, mem_err},   0);
      reset = 1'b1;

      // 1: ALU op R3 = 0x10
      tick();
      drive_e(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'd3);
      tick();
      nop_e();
      #1;
      check("t1_req",      {31'b0, dmem_req},  0);
      check("t1_aluresm",  ALUResultM,         32'h10);
      tick();
      check("t1_regwrw",   {31'b0, RegWriteW}, 1);
      check("t1_waddrw",   {28'b0, WriteAddrW}, 3);
      check("t1_result",   ResultW,            32'h10);

      // 2: zero-wait load from 0x100
      drive_e(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 4'd5);
      tick();
      nop_e();
      dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
      #1;
      check("t2_req",      {31'b0, dmem_req},  1);
      check("t2_we",       {31'b0, dmem_we},   0);
      check("t2_addr",     dmem_addr,          32'h100);
      check("t2_stall",    {31'b0, stallM},    0);
      tick();
      dmem_ready = 1'b0; dmem_rdata = 32'h0;
      #1;
      check("t2_result",   ResultW,            32'hCAFEF00D);
      check("t2_waddrw",   {28'b0, WriteAddrW}, 5);
      check("t2_req_off",  {31'b0, dmem_req},  0);

      // 3: store 0x55 to 0x200, ready after 3 waits; next ALU op must be held
      drive_e(1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h55, 4'd0);
      tick();
      drive_e(1'b0, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd7);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t3_stall",  {31'b0, stallM},    1);
         check("t3_we",     {31'b0, dmem_we},   1);
         check("t3_addr",   dmem_addr,          32'h200);
         check("t3_wdata",  dmem_wdata,         32'h55);
         tick();
         check("t3_bubble", {31'b0, RegWriteW}, 0);
      end
      dmem_ready = 1'b1;
      #1;
      check("t3_done_stall", {31'b0, stallM},  0);
      check("t3_done_req",   {31'b0, dmem_req}, 1);
      tick();
      dmem_ready = 1'b0;
      nop_e();
      #1;
      check("t3_next_alum",  ALUResultM,       32'h77);
      check("t3_next_req",   {31'b0, dmem_req}, 0);
      check("t3_st_regwrw",  {31'b0, RegWriteW}, 0);
      tick();
      check("t3_next_res",   ResultW,          32'h77);
      check("t3_next_wa",    {28'b0, WriteAddrW}, 7);

      // 4: load that never completes, TIMEOUT = 4
      drive_e(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 4'd9);
      tick();
      nop_e();
      dmem_rdata = 32'h12345678;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t4_stall",  {31'b0, stallM},  1);
         check("t4_noerr",  {31'b0, mem_err}, 0);
         tick();
      end
      #1;
      check("t4_abort_stall", {31'b0, stallM}, 0);
      tick();
      check("t4_err",      {31'b0, mem_err},   1);
      check("t4_result",   ResultW,            32'hDEADBEEF);
      check("t4_regwrw",   {31'b0, RegWriteW}, 1);
      check("t4_waddrw",   {28'b0, WriteAddrW}, 9);

      // 5a: failed-condition load never issues
      drive_e(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 32'h0, 4'd1);
      tick();
      nop_e();
      #1;
      check("t5_req",      {31'b0, dmem_req},  0);
      check("t5_stall",    {31'b0, stallM},    0);
      tick();
      check("t5_regwrw",   {31'b0, RegWriteW}, 0);

      // 5b: flushM while stalled is ignored
      drive_e(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 4'd2);
      tick();
      drive_e(1'b0, 1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 4'd4);
      flushM = 1'b1;
      #1;
      check("t5_fl_stall", {31'b0, stallM},    1);
      tick();
      check("t5_fl_hold",  ALUResultM,         32'h500);
      check("t5_fl_rw",    {31'b0, RegWriteM}, 1);
      flushM = 1'b0;
      dmem_ready = 1'b1; dmem_rdata = 32'hABCD0001;
      #1;
      check("t5_fl_done",  {31'b0, stallM},    0);
      tick();
      dmem_ready = 1'b0;
      check("t5_fl_res",   ResultW,            32'hABCD0001);
      check("t5_fl_wa",    {28'b0, WriteAddrW}, 2);
      check("t5_fl_next",  ALUResultM,         32'h99);
      // 5c: flushM with no stall bubbles the incoming instruction
      drive_e(1'b0, 1'b1, 1'b0, 1'b0, 32'h66, 32'h0, 4'd6);
      flushM = 1'b1;
      tick();
      flushM = 1'b0;
      nop_e();
      #1;
      check("t5_flush_rw", {31'b0, RegWriteM}, 0);

      // 6: async reset during WAIT, then misaligned store
      drive_e(1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 32'h0, 4'd8);
      tick();
      nop_e();
      tick();
      check("t6_wait",     {31'b0, stallM},    1);
      reset = 1'b0;
      #1;
      check("t6_req",      {31'b0, dmem_req},  0);
      check("t6_stall",    {31'b0, stallM},    0);
      check("t6_result",   ResultW,            0);
      check("t6_regwrw",   {31'b0, RegWriteW}, 0);
      check("t6_err_clr",  {31'b0, mem_err},   0);
      #1;
      reset = 1'b1;
      tick();
      check("t6_no_wb",    {31'b0, RegWriteW}, 0);
      drive_e(1'b0, 1'b0, 1'b1, 1'b0, 32'h102, 32'h11, 4'd0);
      tick();
      nop_e();
      dmem_ready = 1'b1;
      #1;
      check("t6_mis_addr", dmem_addr,          32'h100);
      check("t6_mis_stall", {31'b0, stallM},   0);
      tick();
      dmem_ready = 1'b0;
      check("t6_mis_err",  {31'b0, mem_err},   1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
